// File: rtl/gf2_div_pkg.sv
// Shared definitions for the bit-serial GF(2)[x] polynomial divider:
// FSM state type, default operand width and counter-width helper.
package gf2_div_pkg;

  localparam int GF2_DIV_N_DEFAULT = 117;

  typedef enum logic [2:0] {
    IDLE,
    NORM,
    DIV,
    DENORM,
    DONE
  } div_state_t;

  // Width of the shift / step counters for a dividend of m bits and divisor of n bits
  function automatic int cnt_w(input int m, input int n);
    return $clog2(m + n);
  endfunction

endpackage

// File: rtl/gf2_div_step.sv
// One long-division step over GF(2): shift the next dividend bit into the
// partial remainder and subtract (XOR) the normalized divisor when the
// leading coefficient is set.
module gf2_div_step
  import gf2_div_pkg::*;
#(
  parameter int N = GF2_DIV_N_DEFAULT
) (
  input  logic [N-2:0] r,
  input  logic         b,
  // low coefficients of the normalized divisor; its x^(N-1) term is always 1
  input  logic [N-2:0] d,
  output logic [N-2:0] r_next,
  output logic         qb
);

  logic [N-1:0] t;

  // form {r, b}, take the leading coefficient as the quotient bit, reduce
  always_comb begin
    t      = {r, b};
    qb     = t[N-1];
    r_next = t[N-2:0] ^ (qb ? d : '0);
  end

endmodule

// File: rtl/gf2_poly_div.sv
// Bit-serial GF(2)[x] divider: quotient and remainder of an M-bit dividend by
// an N-bit divisor, one division step per clock, start/done handshake.
// Optional macro GF2_DIV_QUOTIENT_EN: keeps the quotient register and port;
// without it the block is a pure reducer (remainder only, same latency).
module gf2_poly_div
  import gf2_div_pkg::*;
#(
  parameter int N = GF2_DIV_N_DEFAULT,
  parameter int M = 2 * N - 1
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         start,
  input  logic [M-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
`ifdef GF2_DIV_QUOTIENT_EN
  output logic [M-1:0] quotient,
`endif
  output logic [N-2:0] remainder,
  output logic         div_zero
);

  localparam int CW = cnt_w(M, N);

  div_state_t      state;
  logic [M-1:0]    a;          // dividend shift register, MSB fed first
  logic [N-1:0]    d;          // divisor, left-aligned during NORM
  logic [N-2:0]    r;          // partial remainder
  logic [CW-1:0]   s;          // normalization shift amount
  logic [CW-1:0]   c;          // remaining division steps minus one
  logic            zero_flag;
  logic [N-2:0]    r_next;
`ifdef GF2_DIV_QUOTIENT_EN
  logic [M-1:0]    q;
  logic            qb;
`else
  // quotient bit is not needed when only reducing
  logic            qb_unused;
`endif

  gf2_div_step #(
    .N (N)
  ) u_step (
    .r      (r),
    .b      (a[M-1]),
    .d      (d[N-2:0]),
    .r_next (r_next),
`ifdef GF2_DIV_QUOTIENT_EN
    .qb     (qb)
`else
    .qb     (qb_unused)
`endif
  );

  // control FSM, datapath registers and held result outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      a         <= '0;
      d         <= '0;
      r         <= '0;
      s         <= '0;
      c         <= '0;
      zero_flag <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      remainder <= '0;
      div_zero  <= 1'b0;
`ifdef GF2_DIV_QUOTIENT_EN
      q         <= '0;
      quotient  <= '0;
`endif
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            a         <= dividend;
            d         <= divisor;
            r         <= '0;
            s         <= '0;
            zero_flag <= 1'b0;
`ifdef GF2_DIV_QUOTIENT_EN
            q         <= '0;
`endif
            busy      <= 1'b1;
            state     <= NORM;
          end
        end
        NORM: begin
          if (d == '0) begin
            // zero divisor passes through DENORM with s==0, giving the
            // fixed two-edge latency for this case
            zero_flag <= 1'b1;
            r         <= '0;
`ifdef GF2_DIV_QUOTIENT_EN
            q         <= '0;
`endif
            state     <= DENORM;
          end else if (!d[N-1]) begin
            d <= {d[N-2:0], 1'b0};
            s <= s + CW'(1);
          end else begin
            c     <= s + CW'(M - 1);
            state <= DIV;
          end
        end
        DIV: begin
          // zeros shift in behind the dividend, so b becomes 0 once it is used up
          a <= {a[M-2:0], 1'b0};
          r <= r_next;
`ifdef GF2_DIV_QUOTIENT_EN
          q <= {q[M-2:0], qb};
`endif
          if (c == '0) state <= DENORM;
          else         c     <= c - CW'(1);
        end
        DENORM: begin
          if (s != '0) begin
            r <= r >> 1;
            s <= s - CW'(1);
          end else begin
            remainder <= r;
            div_zero  <= zero_flag;
`ifdef GF2_DIV_QUOTIENT_EN
            quotient  <= q;
`endif
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gf2_poly_div.sv
// Self-checking bench for gf2_poly_div: directed N=4 cases, mid-run reset,
// and randomized N=117 runs against a behavioural polynomial model.
module tb_gf2_poly_div;

  localparam int NS = 4;
  localparam int MS = 7;
  localparam int NB = 117;
  localparam int MB = 233;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          start_s, busy_s, done_s, dz_s;
  logic [MS-1:0] dividend_s;
  logic [NS-1:0] divisor_s;
  logic [NS-2:0] rem_s;
  logic          start_b, busy_b, done_b, dz_b;
  logic [MB-1:0] dividend_b;
  logic [NB-1:0] divisor_b;
  logic [NB-2:0] rem_b;
`ifdef GF2_DIV_QUOTIENT_EN
  logic [MS-1:0] quot_s;
  logic [MB-1:0] quot_b;
`endif

  gf2_poly_div #(.N(NS), .M(MS)) u_small (
    .clk(clk), .rst_n(rst_n), .start(start_s), .dividend(dividend_s),
    .divisor(divisor_s), .busy(busy_s), .done(done_s),
`ifdef GF2_DIV_QUOTIENT_EN
    .quotient(quot_s),
`endif
    .remainder(rem_s), .div_zero(dz_s)
  );

  gf2_poly_div #(.N(NB), .M(MB)) u_big (
    .clk(clk), .rst_n(rst_n), .start(start_b), .dividend(dividend_b),
    .divisor(divisor_b), .busy(busy_b), .done(done_b),
`ifdef GF2_DIV_QUOTIENT_EN
    .quotient(quot_b),
`endif
    .remainder(rem_b), .div_zero(dz_b)
  );

  int n_pass = 0;
  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  function automatic int deg_of(input logic [255:0] v);
    for (int i = 255; i >= 0; i--) if (v[i]) return i;
    return -1;
  endfunction

  function automatic logic [255:0] clmul(input logic [255:0] x, input logic [255:0] y);
    logic [255:0] p = '0;
    for (int i = 0; i < 256; i++) if (y[i]) p ^= x << i;
    return p;
  endfunction

  task automatic ref_div(input logic [255:0] num, input logic [255:0] den,
                         output logic [255:0] q, output logic [255:0] r);
    int dd;
    q  = '0;
    r  = num;
    dd = deg_of(den);
    if (dd < 0) begin
      r = '0;
      return;
    end
    for (int i = deg_of(num); i >= dd; i--)
      if (r[i]) begin
        r ^= den << (i - dd);
        q[i - dd] = 1'b1;
      end
  endtask

  function automatic logic [255:0] rnd(input int bits);
    logic [255:0] v;
    v = {$urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom, $urandom};
    if (bits < 256) v &= (256'd1 << bits) - 256'd1;
    return v;
  endfunction

  // launch one division, count edges after the accepting edge until done
  task automatic run(input bit big, input logic [255:0] dd, input logic [255:0] dv,
                     input bit poke, output int lat);
    @(negedge clk);
    if (big) begin
      dividend_b = dd[MB-1:0]; divisor_b = dv[NB-1:0]; start_b = 1'b1;
    end else begin
      dividend_s = dd[MS-1:0]; divisor_s = dv[NS-1:0]; start_s = 1'b1;
    end
    @(posedge clk);
    #1;
    start_b = 1'b0;
    start_s = 1'b0;
    chk("busy_after_accept", big ? busy_b : busy_s, 1);
    lat = -1;
    for (int k = 1; k <= 1500; k++) begin
      @(posedge clk);
      #1;
      if (big ? done_b : done_s) begin
        lat = k;
        break;
      end
      if (poke && !big) begin
        start_s = (k == 3);
        if (k == 3) begin
          divisor_s  = '0;
          dividend_s = ~dd[MS-1:0];
        end
      end
    end
    if (lat < 0) chk("done_timeout", 0, 1);
    else begin
      chk("busy_in_done", big ? busy_b : busy_s, 0);
      @(posedge clk);
      #1;
      chk("done_one_cycle", big ? done_b : done_s, 0);
    end
  endtask

  int           lat, db, sh, mode;
  logic [255:0] a, b, dd, eq, er;

  initial begin
    start_s = 0; start_b = 0;
    dividend_s = '0; divisor_s = '0; dividend_b = '0; divisor_b = '0;

    #2;
    chk("rst_busy", busy_s, 0);
    chk("rst_done", done_s, 0);
    chk("rst_rem", rem_s, 0);
    chk("rst_dz", dz_s, 0);
    chk("rst_rem_big", rem_b, 0);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("rst_quot", quot_s, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // 0x53 / 0x5, with an ignored start pulse while busy
    run(0, 256'h53, 256'h5, 1, lat);
    chk("t1_lat", lat, 12);
    chk("t1_rem", rem_s, 3);
    chk("t1_dz", dz_s, 0);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("t1_quot", quot_s, 256'h10);
`endif

    run(0, 256'h7F, 256'hB, 0, lat);
    chk("t2_lat", lat, 9);
    chk("t2_rem", rem_s, 0);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("t2_quot", quot_s, 256'hD);
`endif

    run(0, 256'h53, 256'h1, 0, lat);
    chk("t3_lat", lat, 18);
    chk("t3_rem", rem_s, 0);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("t3_quot", quot_s, 256'h53);
`endif

    run(0, 256'h53, 256'h0, 0, lat);
    chk("t4_lat", lat, 2);
    chk("t4_dz", dz_s, 1);
    chk("t4_rem", rem_s, 0);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("t4_quot", quot_s, 0);
`endif

    // asynchronous reset in the middle of DIV
    @(negedge clk);
    dividend_s = 7'h7F; divisor_s = 4'hB; start_s = 1'b1;
    @(posedge clk);
    #1 start_s = 1'b0;
    repeat (4) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", busy_s, 0);
    chk("mid_rst_done", done_s, 0);
    chk("mid_rst_dz", dz_s, 0);
    chk("mid_rst_rem", rem_s, 0);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("mid_rst_quot", quot_s, 0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run(0, 256'h53, 256'h5, 0, lat);
    chk("post_rst_lat", lat, 12);
    chk("post_rst_rem", rem_s, 3);
`ifdef GF2_DIV_QUOTIENT_EN
    chk("post_rst_quot", quot_s, 256'h10);
`endif

    // randomized N=117 runs: exact products, products ^ 1, arbitrary dividends
    for (int it = 0; it < 75; it++) begin
      mode = it % 3;
      db   = (mode == 1) ? $urandom_range(NB - 1, 1) : $urandom_range(NB - 1, 0);
      b    = rnd(db + 1);
      b[db] = 1'b1;
      if (mode == 1) b[0] = 1'b1;
      a    = rnd(NB);
      case (mode)
        0: begin dd = clmul(a, b);          eq = a; er = '0; end
        1: begin dd = clmul(a, b) ^ 256'd1; eq = a; er = 256'd1; end
        default: begin dd = rnd(MB); ref_div(dd, b, eq, er); end
      endcase
      sh = NB - 1 - db;
      run(1, dd, b, 0, lat);
      chk("rnd_lat", lat, MB + 3 * sh + 2);
      chk("rnd_rem", rem_b, er);
      chk("rnd_dz", dz_b, 0);
`ifdef GF2_DIV_QUOTIENT_EN
      chk("rnd_quot", quot_b, eq);
`endif
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
